// File: rtl/rv32imf_irq_source.sv
// Interrupt source block: 64-bit machine timer, software interrupt, registered
// external interrupt and edge-latched fast events, behind a small register port.
module rv32imf_irq_source #(
  parameter int unsigned NUM_FAST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_req_i,
  input  logic                reg_we_i,
  input  logic [2:0]          reg_addr_i,
  input  logic [31:0]         reg_wdata_i,
  output logic [31:0]         reg_rdata_o,
  output logic                reg_rvalid_o,
  input  logic [NUM_FAST-1:0] fast_evt_i,
  input  logic                ext_irq_i,
  input  logic                irq_ack_i,
  input  logic [4:0]          irq_id_i,
  output logic [31:0]         irq_o,
  output logic                irq_sec_o
);

  typedef enum logic [2:0] {
    A_MTIME_LO    = 3'd0,
    A_MTIME_HI    = 3'd1,
    A_MTIMECMP_LO = 3'd2,
    A_MTIMECMP_HI = 3'd3,
    A_MSIP        = 3'd4,
    A_FAST_PEND   = 3'd5,
    A_FAST_EN     = 3'd6,
    A_CTRL        = 3'd7
  } reg_addr_e;

  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         mtimecmp_q, mtimecmp_d;
  logic                msip_q, msip_d;
  logic [NUM_FAST-1:0] fast_pend_q, fast_pend_d;
  logic [NUM_FAST-1:0] fast_en_q, fast_en_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [NUM_FAST-1:0] evt_q;
  logic                arm_q;
  logic                ext_q;
  logic                tirq_q, tirq_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                wr, rd;
  reg_addr_e           addr;
  logic [NUM_FAST-1:0] pend_set, pend_clr;
  logic [31:0]         pend_w, en_w, rd_mux, irq_c;

  always_comb begin
    wr          = reg_req_i & reg_we_i;
    rd          = reg_req_i & ~reg_we_i;
    addr        = reg_addr_e'(reg_addr_i);
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    fast_en_d   = fast_en_q;
    ctrl_d      = ctrl_q;
    pend_set    = '0;
    pend_clr    = '0;
    pend_w      = '0;
    en_w        = '0;
    rd_mux      = '0;
    rdata_d     = rdata_q;
    rvalid_d    = rd;
    tirq_d      = (mtime_q >= mtimecmp_q);

    // A write to either mtime half replaces that cycle's increment.
    if (wr && addr == A_MTIME_LO) begin
      mtime_d[31:0] = reg_wdata_i;
    end else if (wr && addr == A_MTIME_HI) begin
      mtime_d[63:32] = reg_wdata_i;
    end else if (ctrl_q[0]) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr) begin
      case (addr)
        A_MTIMECMP_LO: mtimecmp_d[31:0]  = reg_wdata_i;
        A_MTIMECMP_HI: mtimecmp_d[63:32] = reg_wdata_i;
        A_MSIP:        msip_d            = reg_wdata_i[0];
        A_FAST_EN:     fast_en_d         = reg_wdata_i[NUM_FAST-1:0];
        A_CTRL:        ctrl_d            = reg_wdata_i[1:0];
        default: ;
      endcase
    end

    for (int unsigned k = 0; k < NUM_FAST; k++) begin
      pend_clr[k] = (irq_ack_i && irq_id_i == 5'(16 + k)) ||
                    (wr && addr == A_FAST_PEND && reg_wdata_i[k]);
    end
    // First cycle after reset only primes the edge flops.
    pend_set    = fast_evt_i & ~evt_q & {NUM_FAST{arm_q}};
    fast_pend_d = (fast_pend_q & ~pend_clr) | pend_set;

    pend_w[NUM_FAST-1:0] = fast_pend_q;
    en_w[NUM_FAST-1:0]   = fast_en_q;
    case (addr)
      A_MTIME_LO:    rd_mux = mtime_q[31:0];
      A_MTIME_HI:    rd_mux = mtime_q[63:32];
      A_MTIMECMP_LO: rd_mux = mtimecmp_q[31:0];
      A_MTIMECMP_HI: rd_mux = mtimecmp_q[63:32];
      A_MSIP:        rd_mux = {31'd0, msip_q};
      A_FAST_PEND:   rd_mux = pend_w;
      A_FAST_EN:     rd_mux = en_w;
      A_CTRL:        rd_mux = {30'd0, ctrl_q};
      default:       rd_mux = '0;
    endcase
    if (rd) begin
      rdata_d = rd_mux;
    end

    irq_c                 = '0;
    irq_c[3]              = msip_q;
    irq_c[7]              = tirq_q;
    irq_c[11]             = ext_q;
    irq_c[16 +: NUM_FAST] = fast_pend_q & fast_en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      fast_pend_q <= '0;
      fast_en_q   <= '0;
      ctrl_q      <= '0;
      evt_q       <= '0;
      arm_q       <= 1'b0;
      ext_q       <= 1'b0;
      tirq_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      fast_pend_q <= fast_pend_d;
      fast_en_q   <= fast_en_d;
      ctrl_q      <= ctrl_d;
      evt_q       <= fast_evt_i;
      arm_q       <= 1'b1;
      ext_q       <= ext_irq_i;
      tirq_q      <= tirq_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign irq_o        = irq_c;
  assign irq_sec_o    = ctrl_q[1];
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;

endmodule

// File: tb/tb_rv32imf_irq_source.sv
// Randomized and directed bench for rv32imf_irq_source against a
// cycle-level behavioural model of the register and interrupt rules.
module tb_rv32imf_irq_source;
  localparam int unsigned NF = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_req_i = 1'b0;
  logic          reg_we_i = 1'b0;
  logic [2:0]    reg_addr_i = '0;
  logic [31:0]   reg_wdata_i = '0;
  logic [31:0]   reg_rdata_o;
  logic          reg_rvalid_o;
  logic [NF-1:0] fast_evt_i = '0;
  logic          ext_irq_i = 1'b0;
  logic          irq_ack_i = 1'b0;
  logic [4:0]    irq_id_i = '0;
  logic [31:0]   irq_o;
  logic          irq_sec_o;

  rv32imf_irq_source #(.NUM_FAST(NF)) dut (
    .clk(clk), .rst(rst),
    .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o), .reg_rvalid_o(reg_rvalid_o),
    .fast_evt_i(fast_evt_i), .ext_irq_i(ext_irq_i), .irq_ack_i(irq_ack_i),
    .irq_id_i(irq_id_i), .irq_o(irq_o), .irq_sec_o(irq_sec_o)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [63:0]   m_mtime, m_cmp;
  logic          m_msip, m_armed, m_ext, m_tirq, m_rvalid;
  logic [NF-1:0] m_pend, m_en, m_prev;
  logic [1:0]    m_ctrl;
  logic [31:0]   m_rdata;
  logic [NF-1:0] cur_evt = '0;
  logic          cur_ext = 1'b0;

  task automatic model_reset();
    m_mtime = 64'd0;  m_cmp = {64{1'b1}};
    m_msip = 0; m_armed = 0; m_ext = 0; m_tirq = 0; m_rvalid = 0;
    m_pend = '0; m_en = '0; m_prev = '0; m_ctrl = '0; m_rdata = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v = m_mtime[31:0];
      3'd1: v = m_mtime[63:32];
      3'd2: v = m_cmp[31:0];
      3'd3: v = m_cmp[63:32];
      3'd4: v[0] = m_msip;
      3'd5: for (int k = 0; k < NF; k++) v[k] = m_pend[k];
      3'd6: for (int k = 0; k < NF; k++) v[k] = m_en[k];
      default: v[1:0] = m_ctrl;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_irq();
    logic [31:0] v;
    v = '0;
    v[3] = m_msip; v[7] = m_tirq; v[11] = m_ext;
    for (int k = 0; k < NF; k++) v[16 + k] = m_pend[k] & m_en[k];
    return v;
  endfunction

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    logic          wr, rdq;
    logic [63:0]   n_mtime;
    logic [NF-1:0] n_pend;
    wr  = reg_req_i & reg_we_i;
    rdq = reg_req_i & ~reg_we_i;
    if (wr && reg_addr_i == 3'd0)      n_mtime = {m_mtime[63:32], reg_wdata_i};
    else if (wr && reg_addr_i == 3'd1) n_mtime = {reg_wdata_i, m_mtime[31:0]};
    else if (m_ctrl[0])                n_mtime = m_mtime + 64'd1;
    else                               n_mtime = m_mtime;
    for (int k = 0; k < NF; k++) begin
      if (m_armed && fast_evt_i[k] && !m_prev[k]) n_pend[k] = 1'b1;
      else if ((irq_ack_i && int'(irq_id_i) == 16 + k) ||
               (wr && reg_addr_i == 3'd5 && reg_wdata_i[k])) n_pend[k] = 1'b0;
      else n_pend[k] = m_pend[k];
    end
    m_rvalid = rdq;
    if (rdq) m_rdata = model_read(reg_addr_i);
    m_tirq = (m_mtime >= m_cmp);
    m_ext  = ext_irq_i;
    if (wr) begin
      case (reg_addr_i)
        3'd2: m_cmp[31:0]  = reg_wdata_i;
        3'd3: m_cmp[63:32] = reg_wdata_i;
        3'd4: m_msip = reg_wdata_i[0];
        3'd6: m_en   = reg_wdata_i[NF-1:0];
        3'd7: m_ctrl = reg_wdata_i[1:0];
        default: ;
      endcase
    end
    m_mtime = n_mtime;
    m_pend  = n_pend;
    m_prev  = fast_evt_i;
    m_armed = 1'b1;
  endtask

  task automatic compare_all();
    check("irq_o", irq_o, exp_irq());
    check("irq_sec", {31'd0, irq_sec_o}, {31'd0, m_ctrl[1]});
    check("rvalid", {31'd0, reg_rvalid_o}, {31'd0, m_rvalid});
    if (m_rvalid) check("rdata", reg_rdata_o, m_rdata);
  endtask

  task automatic apply(input logic req, input logic we, input logic [2:0] a,
                       input logic [31:0] wd, input logic [NF-1:0] evt,
                       input logic ext, input logic ack, input logic [4:0] id);
    @(negedge clk);
    compare_all();
    reg_req_i = req; reg_we_i = we; reg_addr_i = a; reg_wdata_i = wd;
    fast_evt_i = evt; ext_irq_i = ext; irq_ack_i = ack; irq_id_i = id;
    cur_evt = evt; cur_ext = ext;
    model_step();
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 3'd0, 32'd0, cur_evt, cur_ext, 1'b0, 5'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    apply(1'b1, 1'b1, a, d, cur_evt, cur_ext, 1'b0, 5'd0);
  endtask

  task automatic ack(input logic [4:0] id);
    apply(1'b0, 1'b0, 3'd0, 32'd0, cur_evt, cur_ext, 1'b1, id);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    apply(1'b1, 1'b0, a, 32'd0, cur_evt, cur_ext, 1'b0, 5'd0);
    idle();
    check(tag, reg_rdata_o, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reg_req_i = 1'b0; irq_ack_i = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("rst_irq", irq_o, 32'd0);
      check("rst_sec", {31'd0, irq_sec_o}, 32'd0);
      check("rst_rvalid", {31'd0, reg_rvalid_o}, 32'd0);
      check("rst_rdata", reg_rdata_o, 32'd0);
    end
    rst = 1'b0;
    model_step();
  endtask

  task automatic random_phase(input int unsigned cycles);
    logic [NF-1:0] evt, flip;
    logic [31:0]   wd;
    for (int unsigned i = 0; i < cycles; i++) begin
      flip = NF'($urandom);
      evt  = ($urandom_range(0, 2) == 0) ? (cur_evt ^ flip) : cur_evt;
      case ($urandom_range(0, 4))
        0: wd = 32'($urandom_range(0, 40));
        1: wd = 32'hFFFF_FFFF;
        2: wd = 32'hFFFF_FFFE;
        3: wd = 32'd0;
        default: wd = $urandom;
      endcase
      apply(1'($urandom), 1'($urandom), 3'($urandom), wd, evt,
            ($urandom_range(0, 3) == 0) ? ~cur_ext : cur_ext,
            ($urandom_range(0, 3) == 0), 5'($urandom_range(10, 31)));
    end
  endtask

  initial begin
    do_reset();

    // Timer compare rise and fall
    wr(3'd2, 32'd10); wr(3'd3, 32'd0); wr(3'd0, 32'd0); wr(3'd1, 32'd0);
    wr(3'd7, 32'd1);
    repeat (14) idle();
    check("timer_on", {31'd0, irq_o[7]}, 32'd1);
    wr(3'd2, 32'd100);
    repeat (2) idle();
    check("timer_off", {31'd0, irq_o[7]}, 32'd0);

    // Carry and wrap
    wr(3'd7, 32'd0); wr(3'd1, 32'd0); wr(3'd0, 32'hFFFF_FFFF); wr(3'd7, 32'd1);
    idle();
    rd(3'd0, 32'd0, "carry_lo");
    rd(3'd1, 32'd1, "carry_hi");
    wr(3'd7, 32'd0); wr(3'd1, 32'hFFFF_FFFF); wr(3'd0, 32'hFFFF_FFFF); wr(3'd7, 32'd1);
    idle();
    rd(3'd0, 32'd0, "wrap_lo");
    rd(3'd1, 32'd0, "wrap_hi");
    wr(3'd7, 32'd0);

    // Fast event, ack matching and non-matching
    wr(3'd6, 32'd1);
    apply(1'b0, 1'b0, 3'd0, 32'd0, 12'h001, 1'b0, 1'b0, 5'd0);
    apply(1'b0, 1'b0, 3'd0, 32'd0, 12'h000, 1'b0, 1'b0, 5'd0);
    idle();
    check("fast_irq", {31'd0, irq_o[16]}, 32'd1);
    rd(3'd5, 32'd1, "fast_pend");
    ack(5'd17); idle();
    check("ack17_nochg", {31'd0, irq_o[16]}, 32'd1);
    ack(5'd0); idle();
    check("ack0_nochg", {31'd0, irq_o[16]}, 32'd1);
    ack(5'd16); idle();
    check("ack16_clr", {31'd0, irq_o[16]}, 32'd0);

    // Collision of set and ack-clear
    apply(1'b0, 1'b0, 3'd0, 32'd0, 12'h004, 1'b0, 1'b1, 5'd18);
    idle();
    rd(3'd5, 32'h4, "collide_pend");
    wr(3'd5, 32'h4);
    rd(3'd5, 32'h0, "w1c_clr");

    // Software, external, secure, masked fields
    wr(3'd4, 32'd1); idle();
    check("msip_irq", {31'd0, irq_o[3]}, 32'd1);
    cur_ext = 1'b1; idle(); idle();
    check("ext_irq", {31'd0, irq_o[11]}, 32'd1);
    wr(3'd7, 32'h2); idle();
    check("sec_bit", {31'd0, irq_sec_o}, 32'd1);
    rd(3'd7, 32'h2, "ctrl_rd");
    wr(3'd6, 32'hFFFF_FFFF); rd(3'd6, 32'h0000_0FFF, "en_mask");
    wr(3'd4, 32'hFFFF_FFFE); rd(3'd4, 32'h0, "msip_mask");
    wr(3'd7, 32'hFFFF_FFFC); rd(3'd7, 32'h0, "ctrl_mask");

    random_phase(3000);

    // Reset during activity with a read in flight and events held high
    wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd7, 32'd1); wr(3'd6, 32'hFFF);
    apply(1'b0, 1'b0, 3'd0, 32'd0, 12'h5A5, 1'b1, 1'b0, 5'd0);
    apply(1'b1, 1'b0, 3'd7, 32'd0, 12'h5A5, 1'b1, 1'b0, 5'd0);
    do_reset();
    cur_ext = 1'b0;
    rd(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(3'd5, 32'h0, "rst_no_edge");
    wr(3'd7, 32'd1);
    repeat (20) idle();
    check("rst_no_timer", {31'd0, irq_o[7]}, 32'd0);

    random_phase(3000);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
